// File: rtl/tri_stream_source_if.sv
// ---------------------------------------------------------------------------
// tri_stream_source_if
//
// Triangle stream bus that one source broadcasts to the pixel array of a
// screen block. Every field describes the triangle on the bus in the current
// cycle. stream_valid marks the cycles that carry a triangle.
//
//   stream_valid  1   a triangle is on the bus (pixel data_in)
//   v1/v2/v3      18  vertex coordinates, Q18.0 signed, [1] = x, [0] = y
//   d1/d2/d3      18  vertex depths, Q6.12 signed
//   color         16  triangle colour
//   denominator   36  signed barycentric denominator
//
// Modports:
//   master - the triangle source, which drives every field
//   slave  - a consumer, which only reads
// ---------------------------------------------------------------------------
interface tri_stream_source_if;

  logic               stream_valid;
  logic signed [17:0] v1 [1:0];
  logic signed [17:0] v2 [1:0];
  logic signed [17:0] v3 [1:0];
  logic signed [17:0] d1;
  logic signed [17:0] d2;
  logic signed [17:0] d3;
  logic        [15:0] color;
  logic signed [35:0] denominator;

  modport master (
    output stream_valid,
    output v1,
    output v2,
    output v3,
    output d1,
    output d2,
    output d3,
    output color,
    output denominator
  );

  modport slave (
    input stream_valid,
    input v1,
    input v2,
    input v3,
    input d1,
    input d2,
    input d3,
    input color,
    input denominator
  );

endinterface

// File: rtl/tri_stream_source.sv
// ---------------------------------------------------------------------------
// tri_stream_source
//
// Feeds the shared triangle stream of one screen block. On an accepted start
// it reads tri_count triangle records from triangle memory, beginning at
// tri_base. It computes each triangle's barycentric denominator and sends the
// triangles out as one gap-free burst with stream_valid held high. It then
// waits for the completion pulse from the pixel array and reports the block as
// done.
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   start                   one-cycle pass request, ignored while busy
//   tri_base, tri_count     first address and triangle count, latched on start
//   tri_rd, tri_addr        triangle memory read strobe and address
//   m_v1..m_v3, m_d1..m_d3  read data vertices and depths, valid one cycle
//   m_color                 after tri_rd
//   strm (master)           triangle stream bus to the pixel array
//   pix_done                pass-complete pulse from the pixel array
//   busy                    high from the accepted start until done
//   done                    one-cycle pass-complete pulse
//
// Pipeline:
//   p0  the read that was issued last cycle returns its data this cycle
//   p1  the read data is captured
//   p2  the denominator is computed and registered with the triangle, and
//       the degenerate case is substituted
// A triangle therefore reaches the bus three edges after its read strobe.
// The first triangle of a pass is on the bus after edge E3, where E0 is the
// edge that samples start.
// ---------------------------------------------------------------------------
module tri_stream_source #(
  parameter int CNT_W = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   tri_base,
  input  logic [CNT_W-1:0]   tri_count,
  output logic               tri_rd,
  output logic [CNT_W-1:0]   tri_addr,
  input  logic signed [17:0] m_v1 [1:0],
  input  logic signed [17:0] m_v2 [1:0],
  input  logic signed [17:0] m_v3 [1:0],
  input  logic signed [17:0] m_d1,
  input  logic signed [17:0] m_d2,
  input  logic signed [17:0] m_d3,
  input  logic        [15:0] m_color,
  input  logic               pix_done,
  output logic               busy,
  output logic               done,
  tri_stream_source_if.master strm
);

  localparam int DATA_W = 18;
  localparam int DEN_W  = 2 * DATA_W;
  localparam int COL_W  = 16;

  localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
  localparam logic signed [DATA_W-1:0] DEGEN_DEPTH = 18'h20000;
  localparam logic signed [DEN_W-1:0]  DEGEN_DEN   = 36'sd1;

  // Barycentric denominator:
  //   (v2y-v3y)(v1x-v3x) + (v3x-v2x)(v1y-v3y)
  // The differences wrap at 18 bits. Each 18x18 product fits in 36 bits. The
  // sum wraps at 36 bits.
  function automatic logic signed [DEN_W-1:0] bary_den(
    input logic signed [DATA_W-1:0] x1,
    input logic signed [DATA_W-1:0] y1,
    input logic signed [DATA_W-1:0] x2,
    input logic signed [DATA_W-1:0] y2,
    input logic signed [DATA_W-1:0] x3,
    input logic signed [DATA_W-1:0] y3
  );
    logic signed [DATA_W-1:0] dy23;
    logic signed [DATA_W-1:0] dx13;
    logic signed [DATA_W-1:0] dx32;
    logic signed [DATA_W-1:0] dy13;
    logic signed [DEN_W-1:0]  prod_a;
    logic signed [DEN_W-1:0]  prod_b;
    dy23   = y2 - y3;
    dx13   = x1 - x3;
    dx32   = x3 - x2;
    dy13   = y1 - y3;
    prod_a = DEN_W'(dy23) * DEN_W'(dx13);
    prod_b = DEN_W'(dx32) * DEN_W'(dy13);
    return prod_a + prod_b;
  endfunction

  // A zero denominator means the three vertices are collinear. Such a
  // triangle still occupies its stream slot. Its denominator is forced to 1
  // and its depths to the most negative value, so that no pixel accepts it.
  function automatic logic is_degenerate(input logic signed [DEN_W-1:0] den);
    return den == '0;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DRAIN,
    S_FINISH
  } state_t;

  // Control (FSM) state
  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             tri_rd_q;
  logic [CNT_W-1:0] addr_q;
  logic [CNT_W-1:0] rd_left_q;

  // Datapath pipeline state
  logic                     vld_p0_q, vld_p0_d;
  logic                     vld_p1_q, vld_p1_d;
  logic                     vld_p2_q, vld_p2_d;

  logic signed [DATA_W-1:0] v1_p1_q [1:0], v1_p1_d [1:0];
  logic signed [DATA_W-1:0] v2_p1_q [1:0], v2_p1_d [1:0];
  logic signed [DATA_W-1:0] v3_p1_q [1:0], v3_p1_d [1:0];
  logic signed [DATA_W-1:0] d1_p1_q, d1_p1_d;
  logic signed [DATA_W-1:0] d2_p1_q, d2_p1_d;
  logic signed [DATA_W-1:0] d3_p1_q, d3_p1_d;
  logic        [COL_W-1:0]  color_p1_q, color_p1_d;

  logic signed [DATA_W-1:0] v1_p2_q [1:0], v1_p2_d [1:0];
  logic signed [DATA_W-1:0] v2_p2_q [1:0], v2_p2_d [1:0];
  logic signed [DATA_W-1:0] v3_p2_q [1:0], v3_p2_d [1:0];
  logic signed [DATA_W-1:0] d1_p2_q, d1_p2_d;
  logic signed [DATA_W-1:0] d2_p2_q, d2_p2_d;
  logic signed [DATA_W-1:0] d3_p2_q, d3_p2_d;
  logic        [COL_W-1:0]  color_p2_q, color_p2_d;
  logic signed [DEN_W-1:0]  den_p2_q, den_p2_d;

  logic signed [DEN_W-1:0]  den_raw;

  // Pass control. rd_left_q holds the latched count and counts down as reads
  // are issued. FINISH is entered in two ways:
  //  - from DRAIN, with done already set on the edge that sampled pix_done;
  //  - from IDLE for an empty pass, with done still clear, so that done rises
  //    one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tri_rd_q  <= 1'b0;
      addr_q    <= '0;
      rd_left_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q    <= 1'b1;
            addr_q    <= tri_base;
            rd_left_q <= tri_count;
            if (tri_count == '0) begin
              state_q <= S_FINISH;
            end else begin
              tri_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // The address wraps modulo 2^CNT_W.
          addr_q    <= addr_q + CNT_ONE;
          rd_left_q <= rd_left_q - CNT_ONE;
          if (rd_left_q == CNT_ONE) begin
            tri_rd_q <= 1'b0;
            state_q  <= S_STREAM;
          end
        end
        S_STREAM: begin
          // Once p0 and p1 are both empty, the last triangle is already in
          // p2 and leaves the bus on this edge.
          if (!vld_p0_q && !vld_p1_q) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pix_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    vld_p0_d   = tri_rd_q;
    vld_p1_d   = vld_p0_q;
    vld_p2_d   = vld_p1_q;

    v1_p1_d    = v1_p1_q;
    v2_p1_d    = v2_p1_q;
    v3_p1_d    = v3_p1_q;
    d1_p1_d    = d1_p1_q;
    d2_p1_d    = d2_p1_q;
    d3_p1_d    = d3_p1_q;
    color_p1_d = color_p1_q;

    v1_p2_d    = v1_p2_q;
    v2_p2_d    = v2_p2_q;
    v3_p2_d    = v3_p2_q;
    d1_p2_d    = d1_p2_q;
    d2_p2_d    = d2_p2_q;
    d3_p2_d    = d3_p2_q;
    color_p2_d = color_p2_q;
    den_p2_d   = den_p2_q;

    den_raw = bary_den(v1_p1_q[1], v1_p1_q[0],
                       v2_p1_q[1], v2_p1_q[0],
                       v3_p1_q[1], v3_p1_q[0]);

    // ---- p0 -> p1: capture the returning read data ----
    if (vld_p0_q) begin
      v1_p1_d    = m_v1;
      v2_p1_d    = m_v2;
      v3_p1_d    = m_v3;
      d1_p1_d    = m_d1;
      d2_p1_d    = m_d2;
      d3_p1_d    = m_d3;
      color_p1_d = m_color;
    end

    // ---- p1 -> p2: denominator and degenerate substitution ----
    // When no triangle arrives, p2 keeps its values. The bus therefore holds
    // the last triangle of a pass until the next pass overwrites it.
    if (vld_p1_q) begin
      v1_p2_d    = v1_p1_q;
      v2_p2_d    = v2_p1_q;
      v3_p2_d    = v3_p1_q;
      color_p2_d = color_p1_q;
      if (is_degenerate(den_raw)) begin
        den_p2_d = DEGEN_DEN;
        d1_p2_d  = DEGEN_DEPTH;
        d2_p2_d  = DEGEN_DEPTH;
        d3_p2_d  = DEGEN_DEPTH;
      end else begin
        den_p2_d = den_raw;
        d1_p2_d  = d1_p1_q;
        d2_p2_d  = d2_p1_q;
        d3_p2_d  = d3_p1_q;
      end
    end
  end

  // Reset clears the data registers as well, so that the whole bus reads 0
  // during reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      v1_p1_q    <= '{default: '0};
      v2_p1_q    <= '{default: '0};
      v3_p1_q    <= '{default: '0};
      d1_p1_q    <= '0;
      d2_p1_q    <= '0;
      d3_p1_q    <= '0;
      color_p1_q <= '0;
      v1_p2_q    <= '{default: '0};
      v2_p2_q    <= '{default: '0};
      v3_p2_q    <= '{default: '0};
      d1_p2_q    <= '0;
      d2_p2_q    <= '0;
      d3_p2_q    <= '0;
      color_p2_q <= '0;
      den_p2_q   <= '0;
    end else begin
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      v1_p1_q    <= v1_p1_d;
      v2_p1_q    <= v2_p1_d;
      v3_p1_q    <= v3_p1_d;
      d1_p1_q    <= d1_p1_d;
      d2_p1_q    <= d2_p1_d;
      d3_p1_q    <= d3_p1_d;
      color_p1_q <= color_p1_d;
      v1_p2_q    <= v1_p2_d;
      v2_p2_q    <= v2_p2_d;
      v3_p2_q    <= v3_p2_d;
      d1_p2_q    <= d1_p2_d;
      d2_p2_q    <= d2_p2_d;
      d3_p2_q    <= d3_p2_d;
      color_p2_q <= color_p2_d;
      den_p2_q   <= den_p2_d;
    end
  end

  assign tri_rd           = tri_rd_q;
  assign tri_addr         = addr_q;
  assign busy             = busy_q;
  assign done             = done_q;

  assign strm.stream_valid = vld_p2_q;
  assign strm.v1           = v1_p2_q;
  assign strm.v2           = v2_p2_q;
  assign strm.v3           = v3_p2_q;
  assign strm.d1           = d1_p2_q;
  assign strm.d2           = d2_p2_q;
  assign strm.d3           = d3_p2_q;
  assign strm.color        = color_p2_q;
  assign strm.denominator  = den_p2_q;

endmodule

// File: tb/tb_tri_stream_source.sv
module tb_tri_stream_source;

  localparam int CNT_W = 12;
  localparam int MEM_N = 1 << CNT_W;

  typedef struct {
    logic signed [17:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic signed [17:0] d1, d2, d3;
    logic        [15:0] col;
  } tri_t;

  typedef struct {
    tri_t               t;
    logic signed [35:0] den;
    logic signed [17:0] d1, d2, d3;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start;
  logic [CNT_W-1:0]   tri_base;
  logic [CNT_W-1:0]   tri_count;
  logic               tri_rd;
  logic [CNT_W-1:0]   tri_addr;
  logic signed [17:0] m_v1 [1:0];
  logic signed [17:0] m_v2 [1:0];
  logic signed [17:0] m_v3 [1:0];
  logic signed [17:0] m_d1, m_d2, m_d3;
  logic        [15:0] m_color;
  logic               pix_done;
  logic               busy;
  logic               done;

  tri_stream_source_if strm ();

  tri_stream_source #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .tri_base  (tri_base),
    .tri_count (tri_count),
    .tri_rd    (tri_rd),
    .tri_addr  (tri_addr),
    .m_v1      (m_v1),
    .m_v2      (m_v2),
    .m_v3      (m_v3),
    .m_d1      (m_d1),
    .m_d2      (m_d2),
    .m_d3      (m_d3),
    .m_color   (m_color),
    .pix_done  (pix_done),
    .busy      (busy),
    .done      (done),
    .strm      (strm)
  );

  always #5 clock = ~clock;

  tri_t             mem [MEM_N];
  exp_t             exp_q [$];
  logic [CNT_W-1:0] addr_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int rd_seen     = 0;
  int sv_seen     = 0;
  int sv_runs     = 0;
  int done_seen   = 0;
  bit sv_prev     = 1'b0;

  // ---------------- reference model ----------------
  function automatic longint wrap18(input longint x);
    logic signed [17:0] lo;
    lo = x[17:0];
    return longint'(lo);
  endfunction

  function automatic logic signed [35:0] model_den(input tri_t t);
    longint a, b, c, d, s;
    a = wrap18(longint'(t.v2y) - longint'(t.v3y));
    b = wrap18(longint'(t.v1x) - longint'(t.v3x));
    c = wrap18(longint'(t.v3x) - longint'(t.v2x));
    d = wrap18(longint'(t.v1y) - longint'(t.v3y));
    s = a * b + c * d;
    return s[35:0];
  endfunction

  function automatic exp_t make_exp(input logic [CNT_W-1:0] a);
    exp_t e;
    e.t   = mem[a];
    e.den = model_den(e.t);
    if (e.den == 36'sd0) begin
      e.den = 36'sd1;
      e.d1  = 18'h20000;
      e.d2  = 18'h20000;
      e.d3  = 18'h20000;
    end else begin
      e.d1 = e.t.d1;
      e.d2 = e.t.d2;
      e.d3 = e.t.d3;
    end
    return e;
  endfunction

  task automatic push_burst(input logic [CNT_W-1:0] base, input int count);
    logic [CNT_W-1:0] a;
    for (int i = 0; i < count; i++) begin
      a = base + CNT_W'(i);
      addr_q.push_back(a);
      exp_q.push_back(make_exp(a));
    end
  endtask

  // ---------------- triangle memory (registered read) ----------------
  always @(posedge clock) begin
    if (tri_rd === 1'b1) begin
      m_v1[1] <= mem[tri_addr].v1x;
      m_v1[0] <= mem[tri_addr].v1y;
      m_v2[1] <= mem[tri_addr].v2x;
      m_v2[0] <= mem[tri_addr].v2y;
      m_v3[1] <= mem[tri_addr].v3x;
      m_v3[0] <= mem[tri_addr].v3y;
      m_d1    <= mem[tri_addr].d1;
      m_d2    <= mem[tri_addr].d2;
      m_d3    <= mem[tri_addr].d3;
      m_color <= mem[tri_addr].col;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (tri_rd === 1'b1) begin
      rd_seen++;
      vectors++;
      if (addr_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_addr: unexpected read at addr %0d, required no read", tri_addr);
      end else begin
        logic [CNT_W-1:0] ea;
        ea = addr_q.pop_front();
        if (tri_addr !== ea) begin
          miscompares++;
          $display("FAIL rd_addr: got %0d, required %0d", tri_addr, ea);
        end
      end
    end
    if (strm.stream_valid === 1'b1) begin
      sv_seen++;
      if (!sv_prev) sv_runs++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_out: extra triangle den=%0d, required stream_valid=0", strm.denominator);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (strm.denominator !== e.den || strm.color !== e.t.col ||
            strm.v1[1] !== e.t.v1x || strm.v1[0] !== e.t.v1y ||
            strm.v2[1] !== e.t.v2x || strm.v2[0] !== e.t.v2y ||
            strm.v3[1] !== e.t.v3x || strm.v3[0] !== e.t.v3y ||
            strm.d1 !== e.d1 || strm.d2 !== e.d2 || strm.d3 !== e.d3) begin
          miscompares++;
          $display("FAIL stream_out: got den=%0d col=%h v1=(%0d,%0d) d=(%0d,%0d,%0d), required den=%0d col=%h v1=(%0d,%0d) d=(%0d,%0d,%0d)",
                   strm.denominator, strm.color, strm.v1[1], strm.v1[0], strm.d1, strm.d2, strm.d3,
                   e.den, e.t.col, e.t.v1x, e.t.v1y, e.d1, e.d2, e.d3);
        end
      end
    end
    sv_prev = (strm.stream_valid === 1'b1);
    if (done === 1'b1) done_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] c);
    @(negedge clock);
    start     = 1'b1;
    tri_base  = b;
    tri_count = c;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_stream_end(input int budget, output bit timed_out);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || strm.stream_valid === 1'b1) && n < budget) begin
      @(negedge clock);
      n++;
    end
    timed_out = (n >= budget);
  endtask

  task automatic pulse_pix_done();
    @(negedge clock);
    pix_done = 1'b1;
    @(negedge clock);
    pix_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || tri_rd !== 1'b0 || strm.stream_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b done=%b tri_rd=%b sv=%b, required all 0", busy, done, tri_rd, strm.stream_valid);
    end
    vectors++;
    if (strm.denominator !== 36'sd0 || strm.color !== 16'h0 || strm.d1 !== 18'sd0 || strm.v3[1] !== 18'sd0 || tri_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_data: den=%0d col=%h d1=%0d v3x=%0d addr=%0d, required all 0",
               strm.denominator, strm.color, strm.d1, strm.v3[1], tri_addr);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || strm.stream_valid !== 1'b0 || tri_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b sv=%b tri_rd=%b, required 0 0 0", busy, strm.stream_valid, tri_rd);
    end
  endtask

  task automatic test_single();
    int k;
    bit found;
    int d0;
    mem[5] = '{v1x: 18'sd0, v1y: 18'sd0, v2x: 18'sd0, v2y: 18'sd10, v3x: 18'sd10, v3y: 18'sd0,
               d1: 18'sd4096, d2: 18'sd2048, d3: -18'sd1024, col: 16'hF800};
    push_burst(12'd5, 1);
    d0 = done_seen;
    do_start(12'd5, 12'd1);
    vectors++;
    if (tri_rd !== 1'b1 || tri_addr !== 12'd5) begin
      miscompares++;
      $display("FAIL single_rd: tri_rd=%b addr=%0d, required 1 at 5", tri_rd, tri_addr);
    end
    k = 1;
    found = 1'b0;
    while (!found && k < 12) begin
      @(negedge clock);
      k++;
      if (strm.stream_valid === 1'b1) found = 1'b1;
    end
    vectors++;
    if (k != 4) begin
      miscompares++;
      $display("FAIL single_latency: stream_valid at cycle %0d, required 4", k);
    end
    vectors++;
    if (strm.denominator !== -36'sd100) begin
      miscompares++;
      $display("FAIL single_den: got %0d, required -100", strm.denominator);
    end
    @(negedge clock);
    vectors++;
    if (strm.stream_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_sv_len: stream_valid=%b, required 0", strm.stream_valid);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: busy=%b done=%b, required 1 0", busy, done);
    end
    pulse_pix_done();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || done_seen - d0 != 1) begin
      miscompares++;
      $display("FAIL single_done_pulse: done=%b pulses=%0d, required 0 and 1", done, done_seen - d0);
    end
  endtask

  task automatic test_wrap();
    int rd0, sv0, run0;
    bit to;
    exp_t last;
    rd0 = rd_seen; sv0 = sv_seen; run0 = sv_runs;
    push_burst(12'hFFE, 4);
    do_start(12'hFFE, 12'd4);
    wait_stream_end(40, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL wrap_timeout: stream not finished in 40 cycles, %0d left", exp_q.size());
    end
    vectors++;
    if (sv_seen - sv0 != 4 || sv_runs - run0 != 1 || rd_seen - rd0 != 4) begin
      miscompares++;
      $display("FAIL wrap_counts: sv=%0d runs=%0d reads=%0d, required 4 1 4", sv_seen - sv0, sv_runs - run0, rd_seen - rd0);
    end
    last = make_exp(12'd1);
    repeat (3) @(negedge clock);
    vectors++;
    if (strm.denominator !== last.den || strm.color !== last.t.col || strm.v2[0] !== last.t.v2y) begin
      miscompares++;
      $display("FAIL wrap_hold: den=%0d col=%h v2y=%0d, required %0d %h %0d",
               strm.denominator, strm.color, strm.v2[0], last.den, last.t.col, last.t.v2y);
    end
    pulse_pix_done();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_degenerate();
    int idx, n, run0;
    run0 = sv_runs;
    mem[101] = '{v1x: 18'sd1, v1y: 18'sd1, v2x: 18'sd2, v2y: 18'sd2, v3x: 18'sd3, v3y: 18'sd3,
                 d1: 18'sd100, d2: 18'sd200, d3: 18'sd300, col: 16'h07E0};
    push_burst(12'd100, 3);
    do_start(12'd100, 12'd3);
    idx = 0;
    n = 0;
    while (idx < 3 && n < 20) begin
      @(negedge clock);
      n++;
      if (strm.stream_valid === 1'b1) begin
        idx++;
        if (idx == 2) begin
          vectors++;
          if (strm.denominator !== 36'sd1 || strm.d1 !== 18'h20000 || strm.d2 !== 18'h20000 || strm.d3 !== 18'h20000) begin
            miscompares++;
            $display("FAIL degen_mid: den=%0d d=(%h,%h,%h), required 1 and 20000 x3",
                     strm.denominator, strm.d1, strm.d2, strm.d3);
          end
        end
      end
    end
    @(negedge clock);
    vectors++;
    if (idx != 3 || sv_runs - run0 != 1 || strm.stream_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL degen_burst: triangles=%0d runs=%0d sv_after=%b, required 3 1 0", idx, sv_runs - run0, strm.stream_valid);
    end
    pulse_pix_done();
    @(negedge clock);
  endtask

  task automatic test_zero();
    int rd0, sv0;
    rd0 = rd_seen; sv0 = sv_seen;
    do_start(12'd7, 12'd0);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_c1: done=%b busy=%b, required 0 1", done, busy);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_c2: done=%b busy=%b, required 1 0", done, busy);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || rd_seen != rd0 || sv_seen != sv0) begin
      miscompares++;
      $display("FAIL zero_c3: done=%b reads=%0d sv=%0d, required 0 0 0", done, rd_seen - rd0, sv_seen - sv0);
    end
  endtask

  task automatic test_ignored();
    int rd0, sv0, run0, d0;
    bit to;
    rd0 = rd_seen; sv0 = sv_seen; run0 = sv_runs; d0 = done_seen;
    push_burst(12'd50, 5);
    do_start(12'd50, 12'd5);
    repeat (5) @(negedge clock);
    start     = 1'b1;
    tri_base  = 12'd900;
    tri_count = 12'd2;
    pix_done  = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    pix_done = 1'b0;
    wait_stream_end(40, to);
    repeat (2) @(negedge clock);
    vectors++;
    if (to || sv_seen - sv0 != 5 || sv_runs - run0 != 1 || rd_seen - rd0 != 5) begin
      miscompares++;
      $display("FAIL ignored_burst: timeout=%b sv=%0d runs=%0d reads=%0d, required 0 5 1 5",
               to, sv_seen - sv0, sv_runs - run0, rd_seen - rd0);
    end
    vectors++;
    if (done_seen != d0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_stray_done: pulses=%0d busy=%b, required 0 1", done_seen - d0, busy);
    end
    pulse_pix_done();
    repeat (3) @(negedge clock);
    vectors++;
    if (done_seen - d0 != 1 || busy !== 1'b0 || rd_seen - rd0 != 5) begin
      miscompares++;
      $display("FAIL ignored_done: pulses=%0d busy=%b reads=%0d, required 1 0 5", done_seen - d0, busy, rd_seen - rd0);
    end
  endtask

  task automatic test_reset_mid();
    int n, seen, sv0, rd0;
    bit to;
    push_burst(12'd200, 6);
    do_start(12'd200, 12'd6);
    n = 0;
    seen = 0;
    while (seen < 3 && n < 20) begin
      @(negedge clock);
      n++;
      if (strm.stream_valid === 1'b1) seen++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (seen != 3 || strm.stream_valid !== 1'b0 || tri_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: seen=%0d sv=%b tri_rd=%b busy=%b done=%b, required 3 0 0 0 0",
               seen, strm.stream_valid, tri_rd, busy, done);
    end
    vectors++;
    if (strm.denominator !== 36'sd0 || strm.v1[1] !== 18'sd0 || strm.d2 !== 18'sd0 || strm.color !== 16'h0 || tri_addr !== '0) begin
      miscompares++;
      $display("FAIL midreset_data: den=%0d v1x=%0d d2=%0d col=%h addr=%0d, required all 0",
               strm.denominator, strm.v1[1], strm.d2, strm.color, tri_addr);
    end
    exp_q.delete();
    addr_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    sv0 = sv_seen;
    rd0 = rd_seen;
    push_burst(12'd300, 2);
    do_start(12'd300, 12'd2);
    wait_stream_end(40, to);
    vectors++;
    if (to || sv_seen - sv0 != 2 || rd_seen - rd0 != 2) begin
      miscompares++;
      $display("FAIL midreset_restart: timeout=%b sv=%0d reads=%0d, required 0 2 2", to, sv_seen - sv0, rd_seen - rd0);
    end
    pulse_pix_done();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  initial begin
    start     = 1'b0;
    pix_done  = 1'b0;
    tri_base  = '0;
    tri_count = '0;
    for (int i = 0; i < MEM_N; i++) begin
      mem[i].v1x = 18'($urandom());
      mem[i].v1y = 18'($urandom());
      mem[i].v2x = 18'($urandom());
      mem[i].v2y = 18'($urandom());
      mem[i].v3x = 18'($urandom());
      mem[i].v3y = 18'($urandom());
      mem[i].d1  = 18'($urandom());
      mem[i].d2  = 18'($urandom());
      mem[i].d3  = 18'($urandom());
      mem[i].col = 16'($urandom());
    end
    test_reset();
    test_single();
    test_wrap();
    test_degenerate();
    test_zero();
    test_ignored();
    test_reset_mid();
    @(negedge clock);
    vectors++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d triangles and %0d reads still expected, required 0 0", exp_q.size(), addr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
